pending_req_encoder: RTL and testbench
======================================

// Module: pending_req_encoder
// PURPOSE
//  Registered N-to-log2(N) priority encoder with request buffering; the inverse of the team's 2-to-4 decoder.
//  - Each req[i] pulse sets a pending bit; pending requests are presented one per handshake as a binary index.
//  - Sits between per-source request lines and a single index consumer, e.g. a decoder-driven select or grant path.
// PARAMETERS
//  N          4  number of request lines (N >= 2)
//  CNT_W      8  width of saturating drop counter
//  MSB_FIRST  0  0: lowest index wins; 1: highest index wins
//  W (local)  $clog2(N)  index width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  req        in   N      request pulses, sampled every edge
//  flush      in   1      synchronous clear of pending and output state
//  out_valid  out  1      out_idx holds a pending request
//  out_idx    out  W      binary index of presented request
//  out_ready  in   1      consumer accepts; fire = out_valid & out_ready
//  pend       out  N      registered pending-request vector
//  busy       out  1      |pend
//  drop_cnt   out  CNT_W  saturating count of cycles with a dropped request
// BEHAVIOUR
//  Reset: async on rst_n low.
//  - pend = 0, out_valid = 0, out_idx = 0, drop_cnt = 0.
//  - Outputs hold those values until the first edge after rst_n rises.
//  Clear mask: clr = fire ? onehot(out_idx) : 0.
//  Next pending: pend_nxt = (pend & ~clr) | req.
//  - A bit fired and re-requested in the same cycle stays set; it is not a drop.
//  Drop: req[i] & pend[i] & ~clr[i] for any i.
//  - The request merges into the existing pending bit.
//  - drop_cnt += 1 per such cycle (once, regardless of how many bits); saturates at all-ones, no wrap.
//  Output register: state machine with two states, IDLE (out_valid = 0) and PRESENT (out_valid = 1).
//  - Load condition: !out_valid | fire.
//  - On load: out_valid <= |pend_nxt; out_idx <= prio(pend_nxt); otherwise hold.
//  - IDLE -> PRESENT when pend_nxt != 0.
//  - PRESENT -> IDLE on fire when pend_nxt == 0; PRESENT -> PRESENT on fire with pend_nxt != 0, or on stall.
//  Latency and throughput:
//  - req sampled at edge k gives out_valid = 1 after edge k (1 cycle), if the output was idle.
//  - Back-to-back fires give one index per cycle.
//  No preemption:
//  - While out_valid & !out_ready, out_idx and out_valid stay stable.
//  - A higher-priority req arriving during the stall only sets its pend bit.
//  Priority:
//  - MSB_FIRST = 0: lowest set index wins.
//  - MSB_FIRST = 1: highest set index wins.
//  - prio(0) = 0, qualified by out_valid = 0.
//  flush = 1 at an edge:
//  - pend <= 0, out_valid <= 0, out_idx <= 0; a pending fire is discarded.
//  - req in that cycle is discarded and counts no drop.
//  - drop_cnt is unchanged.
//  pend reflects state after the edge; busy is combinational from pend.
//  Mid-operation async reset: all state clears immediately, with no partial handshake completion.
// STRUCTURE
//  Shared package enc_pkg:
//  - function idx_to_onehot(idx, N);
//  - function prio_idx(vec, MSB_FIRST) returning W bits;
//  - localparam computation of W.
//  Sub-module prio_enc: combinational N -> {any, idx[W-1:0]} with MSB_FIRST.
//  - Used once on pend_nxt.
//  Top level holds pend, the output register, drop logic and the counter.
// TESTING
//  1. Reset: rst_n = 0 with req = 4'b1111 -> pend = 0, out_valid = 0, out_idx = 0, drop_cnt = 0; all hold until release.
//  2. Single req = 4'b0100 for 1 cycle, out_ready = 1 -> out_valid = 1, out_idx = 2 next cycle; pend = 0, out_valid = 0 the cycle after.
//  3. Burst req = 4'b1011, out_ready = 1 -> indices 0, 1, 3 on consecutive cycles, then idle.
//     - Same stimulus with MSB_FIRST = 1 -> 3, 1, 0.
//  4. Stall: out_idx = 1 valid, out_ready = 0, then req = 4'b0001 -> out_idx stays 1 and pend = 4'b0011.
//     - After release: 1, then 0.
//  5. Drop and saturation, CNT_W = 2:
//     - req[2] twice while pend[2] is set -> drop_cnt = 2; keep dropping -> drop_cnt sticks at 3.
//     - Fire of idx 2 with req[2] in the same cycle -> no increment, pend[2] stays 1.
//  6. flush with req = 4'b1000 and out_valid & out_ready -> next cycle pend = 0, out_valid = 0, drop_cnt unchanged.
//     - Async rst_n pulse mid-burst -> immediate clear.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared helpers for the pending-request encoder: index width, one-hot expansion and priority pick.
// Functions work on MAX_N-wide vectors so they serve any N up to MAX_N; callers cast to their own widths.
package enc_pkg;

  localparam int MAX_N = 64;
  localparam int MAX_W = 6;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } out_state_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_N-1:0] idx_to_onehot(input logic [MAX_W-1:0] idx, input int n);
    logic [MAX_N-1:0] oh;
    oh = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n && idx == i[MAX_W-1:0]) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Last write wins, so scan direction sets which end has priority; empty vector yields 0.
  function automatic logic [MAX_W-1:0] prio_idx(input logic [MAX_N-1:0] vec, input int n,
                                                input bit msb_first);
    logic [MAX_W-1:0] r;
    r = '0;
    if (msb_first) begin
      for (int i = 0; i < MAX_N; i++) begin
        if (i < n && vec[i]) r = i[MAX_W-1:0];
      end
    end else begin
      for (int i = MAX_N - 1; i >= 0; i--) begin
        if (i < n && vec[i]) r = i[MAX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pending_req_encoder_prio_enc.sv
// Combinational N -> {any, idx} priority encoder; idx is 0 when nothing is set.
module prio_enc
  import enc_pkg::*;
#(
  parameter int N         = 4,
  parameter int MSB_FIRST = 0,
  localparam int W        = idx_w(N)
) (
  input  logic [N-1:0] vec,
  output logic         any,
  output logic [W-1:0] idx
);

  assign any = |vec;
  assign idx = W'(prio_idx(MAX_N'(vec), N, MSB_FIRST != 0));

endmodule

// File: rtl/pending_req_encoder.sv
// Buffers request pulses as pending bits and presents them one per valid/ready handshake as a binary index.
// Output register loads only when empty or firing, so a stalled index never changes under the consumer.
module pending_req_encoder
  import enc_pkg::*;
#(
  parameter int N         = 4,
  parameter int CNT_W     = 8,
  parameter int MSB_FIRST = 0,
  localparam int W        = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             flush,
  output logic             out_valid,
  output logic [W-1:0]     out_idx,
  input  logic             out_ready,
  output logic [N-1:0]     pend,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  out_state_e   state, state_nxt;
  logic [W-1:0] idx_nxt;
  logic         fire;
  logic [N-1:0] clr;
  logic [N-1:0] pend_nxt;
  logic         drop;
  logic         nxt_any;
  logic [W-1:0] nxt_idx;

  assign out_valid = (state == ST_PRESENT);
  assign fire      = out_valid & out_ready;
  assign clr       = fire ? N'(idx_to_onehot(MAX_W'(out_idx), N)) : '0;
  assign pend_nxt  = (pend & ~clr) | req;
  // A bit fired and re-requested in the same cycle is a fresh request, not a drop.
  assign drop      = |(req & pend & ~clr);
  assign busy      = |pend;

  prio_enc #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio (
    .vec (pend_nxt),
    .any (nxt_any),
    .idx (nxt_idx)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = out_idx;
    if (flush) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = nxt_any ? ST_PRESENT : ST_IDLE;
          idx_nxt   = nxt_idx;
        end
        ST_PRESENT: begin
          if (fire) begin
            state_nxt = nxt_any ? ST_PRESENT : ST_IDLE;
            idx_nxt   = nxt_idx;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      out_idx  <= '0;
      pend     <= '0;
      drop_cnt <= '0;
    end else begin
      state   <= state_nxt;
      out_idx <= idx_nxt;
      pend    <= flush ? '0 : pend_nxt;
      if (!flush && drop && drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pending_req_encoder.sv
// Drives two encoders (lowest-first with 2-bit counter, highest-first with 8-bit counter) from shared inputs
// and compares both against a cycle-level behavioural model, plus directed scenarios with fixed expectations.
module tb_pending_req_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       flush;
  logic       out_ready;

  logic       lo_vld, hi_vld, lo_busy, hi_busy;
  logic [1:0] lo_idx, hi_idx;
  logic [3:0] lo_pend, hi_pend;
  logic [1:0] lo_cnt;
  logic [7:0] hi_cnt;

  int checks = 0;
  int errors = 0;

  // Model state per instance: 0 = lowest-first/CNT_W=2, 1 = highest-first/CNT_W=8.
  bit m_pend[2][4];
  bit m_vld[2];
  int m_idx[2];
  int m_cnt[2];
  int cnt_max[2] = '{3, 255};

  always #5 clk = ~clk;

  pending_req_encoder #(.N(4), .CNT_W(2), .MSB_FIRST(0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .req(req), .flush(flush),
    .out_valid(lo_vld), .out_idx(lo_idx), .out_ready(out_ready),
    .pend(lo_pend), .busy(lo_busy), .drop_cnt(lo_cnt)
  );

  pending_req_encoder #(.N(4), .CNT_W(8), .MSB_FIRST(1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .req(req), .flush(flush),
    .out_valid(hi_vld), .out_idx(hi_idx), .out_ready(out_ready),
    .pend(hi_pend), .busy(hi_busy), .drop_cnt(hi_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) m_pend[d][i] = 1'b0;
      m_vld[d] = 1'b0;
      m_idx[d] = 0;
      m_cnt[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (flush) begin
        for (int i = 0; i < 4; i++) m_pend[d][i] = 1'b0;
        m_vld[d] = 1'b0;
        m_idx[d] = 0;
      end else begin
        bit fire, dropped, found;
        fire    = m_vld[d] && out_ready;
        dropped = 1'b0;
        for (int i = 0; i < 4; i++)
          if (req[i] && m_pend[d][i] && !(fire && m_idx[d] == i)) dropped = 1'b1;
        if (fire) m_pend[d][m_idx[d]] = 1'b0;
        for (int i = 0; i < 4; i++) if (req[i]) m_pend[d][i] = 1'b1;
        if (dropped && m_cnt[d] < cnt_max[d]) m_cnt[d]++;
        if (!m_vld[d] || fire) begin
          found    = 1'b0;
          m_idx[d] = 0;
          for (int k = 0; k < 4; k++) begin
            int i;
            i = (d == 0) ? k : 3 - k;
            if (!found && m_pend[d][i]) begin
              found    = 1'b1;
              m_idx[d] = i;
            end
          end
          m_vld[d] = found;
        end
      end
    end
  endtask

  function automatic int model_pend(input int d);
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_pend[d][i]) v |= (1 << i);
    return v;
  endfunction

  task automatic compare_all();
    check("lo_vld",  lo_vld,  m_vld[0]);
    check("lo_idx",  lo_idx,  m_idx[0]);
    check("lo_pend", lo_pend, model_pend(0));
    check("lo_busy", lo_busy, model_pend(0) != 0);
    check("lo_cnt",  lo_cnt,  m_cnt[0]);
    check("hi_vld",  hi_vld,  m_vld[1]);
    check("hi_idx",  hi_idx,  m_idx[1]);
    check("hi_pend", hi_pend, model_pend(1));
    check("hi_busy", hi_busy, model_pend(1) != 0);
    check("hi_cnt",  hi_cnt,  m_cnt[1]);
  endtask

  // One clock: advance the model with the inputs present before the edge, then sample after it.
  task automatic cycle();
    if (rst_n) model_step();
    else model_reset();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b1111; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    check("rst_vld_now", lo_vld, 0);
    repeat (2) cycle();
    check("rst_vld",  lo_vld,  0);
    check("rst_idx",  lo_idx,  0);
    check("rst_pend", lo_pend, 0);
    check("rst_cnt",  lo_cnt,  0);
    rst_n = 1'b1; req = 4'b0000;
    cycle();

    // single request, one-cycle latency
    req = 4'b0100; out_ready = 1'b1;
    cycle();
    check("single_vld", lo_vld, 1);
    check("single_idx", lo_idx, 2);
    req = 4'b0000;
    cycle();
    check("single_pend_clr", lo_pend, 0);
    check("single_idle", lo_vld, 0);

    // burst: lowest-first 0,1,3 and highest-first 3,1,0
    req = 4'b1011;
    cycle();
    check("burst_lo0", lo_idx, 0); check("burst_hi0", hi_idx, 3);
    req = 4'b0000;
    cycle();
    check("burst_lo1", lo_idx, 1); check("burst_hi1", hi_idx, 1);
    cycle();
    check("burst_lo2", lo_idx, 3); check("burst_hi2", hi_idx, 0);
    check("burst_vld2", lo_vld, 1);
    cycle();
    check("burst_idle_lo", lo_vld, 0); check("burst_idle_hi", hi_vld, 0);

    // stall: higher-priority request must not preempt
    out_ready = 1'b0; req = 4'b0010;
    cycle();
    check("stall_idx_a", lo_idx, 1);
    req = 4'b0001;
    cycle();
    check("stall_idx_b", lo_idx, 1);
    check("stall_vld",   lo_vld, 1);
    check("stall_pend",  lo_pend, 4'b0011);
    req = 4'b0000; out_ready = 1'b1;
    cycle();
    check("release_idx", lo_idx, 0);
    cycle();
    check("release_idle", lo_vld, 0);

    // drops and saturation on the 2-bit counter
    out_ready = 1'b0; req = 4'b0100;
    cycle();
    check("drop_cnt0", lo_cnt, 0);
    cycle();
    check("drop_cnt1", lo_cnt, 1);
    cycle();
    check("drop_cnt2", lo_cnt, 2);
    cycle();
    check("drop_cnt3", lo_cnt, 3);
    cycle();
    check("drop_sat", lo_cnt, 3);
    check("drop_hi4", hi_cnt, 4);
    out_ready = 1'b1;
    cycle();
    check("refire_cnt",  hi_cnt, 4);
    check("refire_pend", lo_pend, 4'b0100);
    check("refire_vld",  lo_vld, 1);
    req = 4'b0000;
    cycle();

    // flush discards pending, output and concurrent requests, keeps counters
    out_ready = 1'b0; req = 4'b0011;
    cycle();
    flush = 1'b1; req = 4'b1010; out_ready = 1'b1;
    cycle();
    check("flush_pend", lo_pend, 0);
    check("flush_vld",  lo_vld, 0);
    check("flush_idx",  lo_idx, 0);
    check("flush_cnt_lo", lo_cnt, 3);
    check("flush_cnt_hi", hi_cnt, 4);
    flush = 1'b0; req = 4'b0000;
    cycle();

    // async reset in the middle of a burst clears state before any edge
    req = 4'b1111; out_ready = 1'b1;
    cycle();
    req = 4'b0000;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_vld",  lo_vld, 0);
    check("arst_pend", lo_pend, 0);
    check("arst_cnt",  hi_cnt, 0);
    check("arst_idx",  hi_idx, 0);
    cycle();
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      req       = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
